risc_control_unit: RTL
======================

Name: risc_control_unit

Overview:
- Instruction sequencer that drives the register/ALU datapath.
- Accepts one 24-bit instruction per valid/ready handshake and latches it.
- Steps a Moore FSM that emits the datapath's register-load enables (reg_sig) and bus-drive enables (tri_sig), holding the latched instruction on func.
- Sits between instruction fetch (upstream) and the datapath (downstream).

Parameters:
INSTR_W, 24, instruction width; only 24 is supported.
NUM_REGS, 16, general registers r0..r15; only 16 is supported.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
instr  input  24  instruction from fetch
instr_valid  input  1  instr is valid this cycle
instr_ready  output  1  unit can accept an instruction (high only in IDLE)
func  output  24  latched instruction register (ir) to the datapath; [23:20] ALU op, [15:0] immediate
reg_sig  output  19  load enables: [15:0] r0..r15, [16] G, [17] A, [18] reserved (always 0)
tri_sig  output  19  bus drive enables: [15:0] r0..r15, [16] G, [17] immediate, [18] PC
done  output  1  one-cycle pulse during the final step of each instruction
pc_inc  output  1  one-cycle pulse in the cycle after accept; fetch advances its PC
illegal  output  1  undefined opcode trapped (see Optional Feature)

Behaviour:
- Instruction format:
  - [23:20] op; [19:16] rx (destination/first operand); [15:12] ry (second operand); [15:0] immediate.
  - Op encoding: 0000 LDI rx,imm; 0001 MOV rx,ry; 0010 STPC rx.
  - ALU ops 0011 ADD, 0100 SUB, 0101 AND, 0110 OR, 0111 XOR, 1000 NOT, 1001 SHL. The ALU consumes func[23:20] directly.
  - Ops 1010-1111 are undefined.
- Reset (reset==0 at a rising edge): state<=IDLE, ir<=0. While in IDLE after reset, reg_sig=0, tri_sig=0, done=0, pc_inc=0, illegal=0, instr_ready=1. Reset overrides any in-flight instruction; no partial enables are issued in the following cycle.
- States: IDLE, T1, T2, T3, TRAP. State and ir are registered; outputs decode combinationally from state and ir.
- Accept: in IDLE, if instr_valid at a rising edge, then ir<=instr and state<=T1. instr_ready=0 in all other states; instr_valid is ignored there.
- T1:
  - pc_inc=1.
  - LDI: tri_sig[17]=1, reg_sig[rx]=1, done=1, next state IDLE.
  - MOV: tri_sig[ry]=1, reg_sig[rx]=1, done=1, next IDLE. If rx==ry, the same register is driven and loaded; this is legal and has no effect.
  - STPC: tri_sig[18]=1, reg_sig[rx]=1, done=1, next IDLE.
  - ALU ops: tri_sig[rx]=1, reg_sig[17]=1 (A<=rx), next T2.
- T2 (ALU only): tri_sig[ry]=1, reg_sig[16]=1 (G<=A op ry), next T3. NOT and SHL still execute this step; ry is don't-care in the ALU.
- T3 (ALU only): tri_sig[16]=1, reg_sig[rx]=1, done=1, next IDLE.
- Latency, accept edge to done: 1 cycle for LDI/MOV/STPC; 3 cycles for ALU ops.
- Maximum throughput is one instruction per (steps+1) cycles, because instr_ready is low in the final step.
- Invariants:
  - At most one tri_sig bit is high in any cycle.
  - reg_sig[18] is always 0.
  - func is stable from accept until the next accept.

Optional Feature:
- Macro CTRL_ILLEGAL_TRAP_EN.
- With the macro defined: an undefined op in T1 issues no enables, sets illegal=1 and moves to TRAP. TRAP holds instr_ready=0, all enables 0 and illegal=1 until reset.
- Without the macro: an undefined op is a NOP. T1 issues no enables, pc_inc=1, done=1, next IDLE. The TRAP state is not built and illegal is tied to 0.

Test Plan:
- Hold reset=0 for 2 cycles, then release -> reg_sig=0, tri_sig=0, done=0, instr_ready=1, func=0x000000.
- LDI r3,0x1234 (instr=0x031234) with valid=1 for one cycle -> next cycle: tri_sig=0x20000, reg_sig=0x00008, done=1, pc_inc=1, func=0x031234; the cycle after: instr_ready=1.
- ADD r1,r2 (instr=0x312000) -> T1: tri_sig=0x00002, reg_sig=0x20000; T2: tri_sig=0x00004, reg_sig=0x10000; T3: tri_sig=0x10000, reg_sig=0x00002, done=1; instr_ready=0 for all three cycles.
- STPC r15 (0x2F0000) followed immediately by MOV r0,r15 (0x10F000) with valid held high -> first instruction accepted, second accepted on the IDLE edge after done; MOV T1: tri_sig=0x08000, reg_sig=0x00001.
- Drive reset=0 during T2 of a SUB -> next cycle: IDLE, all enables 0, no done pulse, func=0.
- Undefined op 0xA00000 -> with CTRL_ILLEGAL_TRAP_EN: illegal=1 and instr_ready=0 persist until reset. Without it: done=1 in T1, no enables, back to IDLE.

Source files
------------

// File: rtl/risc_control_unit.sv
// Instruction sequencer: latches one instruction per handshake, steps T1..T3.
// Optional CTRL_ILLEGAL_TRAP_EN: undefined ops trap in TRAP until reset.
module risc_control_unit #(
    parameter int INSTR_W  = 24,
    parameter int NUM_REGS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INSTR_W-1:0]    instr,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    output logic [INSTR_W-1:0]    func,
    output logic [NUM_REGS+2:0]   reg_sig,
    output logic [NUM_REGS+2:0]   tri_sig,
    output logic                  done,
    output logic                  pc_inc,
    output logic                  illegal
);

    localparam int G_IDX   = NUM_REGS;
    localparam int A_IDX   = NUM_REGS + 1;
    localparam int IMM_IDX = NUM_REGS + 1;
    localparam int PC_IDX  = NUM_REGS + 2;

`ifdef CTRL_ILLEGAL_TRAP_EN
    typedef enum logic [2:0] {IDLE, T1, T2, T3, TRAP} state_t;
`else
    typedef enum logic [2:0] {IDLE, T1, T2, T3} state_t;
`endif

    state_t state_q, state_d;
    logic [INSTR_W-1:0] ir;

    logic [3:0] op, rx, ry;
    logic is_ldi, is_mov, is_stpc, is_alu;

    assign op = ir[23:20];
    assign rx = ir[19:16];
    assign ry = ir[15:12];

    assign is_ldi  = (op == 4'd0);
    assign is_mov  = (op == 4'd1);
    assign is_stpc = (op == 4'd2);
    assign is_alu  = (op >= 4'd3) && (op <= 4'd9);

    assign func = ir;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            ir      <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && instr_valid)
                ir <= instr;
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        reg_sig     = '0;
        tri_sig     = '0;
        done        = 1'b0;
        pc_inc      = 1'b0;
        illegal     = 1'b0;
        unique case (state_q)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid)
                    state_d = T1;
            end
            T1: begin
                pc_inc = 1'b1;
                unique case (1'b1)
                    is_ldi: begin
                        tri_sig[IMM_IDX] = 1'b1;
                        reg_sig[rx]      = 1'b1;
                        done             = 1'b1;
                        state_d          = IDLE;
                    end
                    is_mov: begin
                        tri_sig[ry] = 1'b1;
                        reg_sig[rx] = 1'b1;
                        done        = 1'b1;
                        state_d     = IDLE;
                    end
                    is_stpc: begin
                        tri_sig[PC_IDX] = 1'b1;
                        reg_sig[rx]     = 1'b1;
                        done            = 1'b1;
                        state_d         = IDLE;
                    end
                    is_alu: begin
                        tri_sig[rx]    = 1'b1;
                        reg_sig[A_IDX] = 1'b1;
                        state_d        = T2;
                    end
                    default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        illegal = 1'b1;
                        state_d = TRAP;
`else
                        done    = 1'b1;
                        state_d = IDLE;
`endif
                    end
                endcase
            end
            T2: begin
                // ry is a don't-care for NOT/SHL but is still driven
                tri_sig[ry]    = 1'b1;
                reg_sig[G_IDX] = 1'b1;
                state_d        = T3;
            end
            T3: begin
                tri_sig[G_IDX] = 1'b1;
                reg_sig[rx]    = 1'b1;
                done           = 1'b1;
                state_d        = IDLE;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            TRAP: begin
                illegal = 1'b1;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
